// File: rtl/score_seg_display_pkg.sv
// Shared game definitions for the score display.
// Holds the FSM state encoding, the default WIN/LOSE thresholds, the glyph
// segment patterns and the display-code helpers used by the sequencer and
// the decoder.
package score_seg_display_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_PLAY = 2'd0;
  localparam logic [1:0] ST_WIN  = 2'd1;
  localparam logic [1:0] ST_LOSE = 2'd2;

  // Default game thresholds
  localparam logic [3:0] WIN_SCORE_DEF  = 4'd10;
  localparam logic [3:0] MISS_LIMIT_DEF = 4'd5;

  // Segment patterns {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  // Display code: MSB clear selects hex digit 0-F in the low nibble,
  // MSB set selects a glyph or blank.
  typedef logic [4:0] disp_code_t;

  localparam disp_code_t CODE_BLANK = 5'h10;
  localparam disp_code_t CODE_P     = 5'h11;
  localparam disp_code_t CODE_C     = 5'h12;
  localparam disp_code_t CODE_E     = 5'h13;

  function automatic disp_code_t hex_code(input logic [3:0] v);
    return {1'b0, v};
  endfunction

  // Ones digit of a 0-15 value
  function automatic logic [3:0] ones_digit(input logic [3:0] v);
    return (v >= 4'd10) ? (v - 4'd10) : v;
  endfunction

endpackage

// File: rtl/score_seg_display_if.sv
// Game status bus into the score display.
//   score : hit count, 0-15
//   miss  : miss count, 0-15
//   dir   : player direction code
// master drives the bus (game logic), slave receives it (display).
interface score_seg_display_if;
  logic [3:0] score;
  logic [3:0] miss;
  logic [1:0] dir;

  modport master (output score, miss, dir);
  modport slave  (input  score, miss, dir);
endinterface

// File: rtl/seg7_decode.sv
// Combinational 7-segment decoder.
//   code : display code (hex 0-F, or glyph/blank with MSB set)
//   seg  : segments {g,f,e,d,c,b,a}, active-low
// The code is one bit wider than a hex nibble so glyphs and blank do not
// collide with the hex digits.
module seg7_decode
  import score_seg_display_pkg::*;
(
  input  disp_code_t  code,
  output logic [6:0]  seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      5'h00: seg = 7'b1000000;
      5'h01: seg = 7'b1111001;
      5'h02: seg = 7'b0100100;
      5'h03: seg = 7'b0110000;
      5'h04: seg = 7'b0011001;
      5'h05: seg = 7'b0010010;
      5'h06: seg = 7'b0000010;
      5'h07: seg = 7'b1111000;
      5'h08: seg = 7'b0000000;
      5'h09: seg = 7'b0010000;
      5'h0A: seg = 7'b0001000;
      5'h0B: seg = 7'b0000011;
      5'h0C: seg = 7'b1000110;
      5'h0D: seg = 7'b0100001;
      5'h0E: seg = 7'b0000110;
      5'h0F: seg = 7'b0001110;
      CODE_P: seg = SEG_P;
      CODE_C: seg = SEG_C;
      CODE_E: seg = SEG_E;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_seg_display.sv
// Scanned 8-digit score display with PLAY/WIN/LOSE game state.
//   clk       : system clock
//   rst       : asynchronous reset, active-low
//   game      : score/miss/dir status bus (slave)
//   an        : digit enables, active-low, one-hot-low while scanning
//   seg       : segments {g,f,e,d,c,b,a}, active-low
//   dp        : decimal point, active-low, always off
//   game_over : high in WIN or LOSE
//   win       : high only in WIN
// Slot map: 7 score tens, 6 score ones, 5 miss tens, 4 miss ones,
// 3 blank, 2 dir, 1 blank, 0 state glyph.
module score_seg_display
  import score_seg_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned BLINK_DIV  = 250,
  parameter logic [3:0]  WIN_SCORE  = WIN_SCORE_DEF,
  parameter logic [3:0]  MISS_LIMIT = MISS_LIMIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  score_seg_display_if.slave   game,
  output logic [7:0]           an,
  output logic [6:0]           seg,
  output logic                 dp,
  output logic                 game_over,
  output logic                 win
);

  localparam int unsigned SCAN_W  = $clog2(SCAN_DIV + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_DIV + 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [3:0]         score_r, miss_r, snap_score, snap_miss;
  logic [1:0]         dir_r, snap_dir;
  logic [1:0]         state, next_state;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [2:0]         slot;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic               scan_wrap, frame_wrap;
  logic [3:0]         show_score, show_miss;
  logic [1:0]         show_dir;
  disp_code_t         code;
  logic [6:0]         seg_dec;

  assign dp = 1'b1;

  // LOSE is checked first so a simultaneous hit on both thresholds loses.
  always_comb begin
    next_state = state;
    if (state == ST_PLAY) begin
      if (miss_r >= MISS_LIMIT)
        next_state = ST_LOSE;
      else if (score_r >= WIN_SCORE)
        next_state = ST_WIN;
    end
  end

  // Input registers, FSM, snapshot and status flags.
  // game_over/win use next_state so they rise together with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_r    <= '0;
      miss_r     <= '0;
      dir_r      <= '0;
      snap_score <= '0;
      snap_miss  <= '0;
      snap_dir   <= '0;
      state      <= ST_PLAY;
      game_over  <= 1'b0;
      win        <= 1'b0;
    end else begin
      score_r   <= game.score;
      miss_r    <= game.miss;
      dir_r     <= game.dir;
      state     <= next_state;
      game_over <= (next_state != ST_PLAY);
      win       <= (next_state == ST_WIN);
      if (state == ST_PLAY && next_state != ST_PLAY) begin
        snap_score <= score_r;
        snap_miss  <= miss_r;
        snap_dir   <= dir_r;
      end
    end
  end

  assign scan_wrap  = (scan_cnt == SCAN_LAST);
  assign frame_wrap = scan_wrap && (slot == 3'd7);

  // Scan timing and blink phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt    <= '0;
      slot        <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (scan_wrap) begin
        scan_cnt <= '0;
        slot     <= slot + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end

      if (state == ST_PLAY) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (frame_wrap) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // PLAY shows live values; the end states show the frozen snapshot.
  always_comb begin
    show_score = (state == ST_PLAY) ? score_r : snap_score;
    show_miss  = (state == ST_PLAY) ? miss_r  : snap_miss;
    show_dir   = (state == ST_PLAY) ? dir_r   : snap_dir;
  end

  // Tens digit of a 0-15 value is either 1 or suppressed.
  always_comb begin
    code = CODE_BLANK;
    case (slot)
      3'd7: code = (show_score >= 4'd10) ? hex_code(4'd1) : CODE_BLANK;
      3'd6: code = hex_code(ones_digit(show_score));
      3'd5: code = (show_miss >= 4'd10) ? hex_code(4'd1) : CODE_BLANK;
      3'd4: code = hex_code(ones_digit(show_miss));
      3'd2: code = hex_code({2'b00, show_dir});
      3'd0: begin
        case (state)
          ST_PLAY: code = CODE_P;
          ST_WIN:  code = CODE_C;
          default: code = CODE_E;
        endcase
      end
      default: code = CODE_BLANK;
    endcase
  end

  seg7_decode u_seg7_decode (
    .code (code),
    .seg  (seg_dec)
  );

  // an and seg are registered from the same slot so they switch together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else begin
      an  <= (state != ST_PLAY && blink_phase) ? 8'hFF : ~(8'b1 << slot);
      seg <= seg_dec;
    end
  end

endmodule
